// File: rtl/fop_arbiter.sv
// Round-robin arbiter sharing one two-operand AXI-Stream FP operator among NREQ requesters.
// Optional orphan-result check enabled by defining FOP_ARB_ERRCHK_EN.
module fop_arbiter #(
  parameter int NREQ      = 3,
  parameter int DATA_SIZE = 32,
  parameter int MAX_OUT   = 8
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*DATA_SIZE-1:0] req_a,
  input  logic [NREQ*DATA_SIZE-1:0] req_b,
  output logic [NREQ-1:0]           rsp_valid,
  input  logic [NREQ-1:0]           rsp_ready,
  output logic [DATA_SIZE-1:0]      rsp_data,
  output logic                      op_a_tvalid,
  input  logic                      op_a_tready,
  output logic [DATA_SIZE-1:0]      op_a_tdata,
  output logic                      op_b_tvalid,
  input  logic                      op_b_tready,
  output logic [DATA_SIZE-1:0]      op_b_tdata,
  input  logic                      op_r_tvalid,
  output logic                      op_r_tready,
  input  logic [DATA_SIZE-1:0]      op_r_tdata,
  output logic                      busy,
  output logic                      err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int AW = $clog2(MAX_OUT);
  localparam int CW = $clog2(MAX_OUT + 1);

  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        grant_idx;
  logic [NREQ-1:0]      grant;
  logic                 grant_any;
  logic                 a_pend, b_pend;
  logic [DATA_SIZE-1:0] a_q, b_q;
  logic                 a_hs, b_hs;
  logic                 slot_free;
  logic                 cnt_ok;
  logic [CW-1:0]        out_cnt;
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [PW-1:0]        tag_mem [MAX_OUT];
  logic [PW-1:0]        head;
  logic [NREQ-1:0]      head_oh;
  logic                 fifo_empty;
  logic                 pop;

  assign a_hs       = a_pend & op_a_tready;
  assign b_hs       = b_pend & op_b_tready;
  // A half that is not pending counts as done; an empty register is therefore free.
  assign slot_free  = (~a_pend | a_hs) & (~b_pend | b_hs);
  assign cnt_ok     = out_cnt < CW'(MAX_OUT);
  // The tag FIFO holds exactly one entry per outstanding operation.
  assign fifo_empty = (out_cnt == '0);
  assign head       = tag_mem[rd_ptr];

  always_comb begin
    int idx;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx] && slot_free && cnt_ok) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = PW'(idx);
      end
    end
  end

  assign grant_any = |grant;
  assign req_ready = grant;

  always_comb begin
    head_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      head_oh[i] = (head == PW'(i));
    end
  end

  assign rsp_valid = (op_r_tvalid && !fifo_empty) ? head_oh : '0;
  assign rsp_data  = op_r_tdata;

`ifdef FOP_ARB_ERRCHK_EN
  logic err_q;

  // Orphan results are swallowed so the operator never deadlocks.
  assign op_r_tready = fifo_empty ? op_r_tvalid : |(rsp_ready & head_oh);
  assign err         = err_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      err_q <= 1'b0;
    end else if (op_r_tvalid && fifo_empty) begin
      err_q <= 1'b1;
    end
  end
`else
  assign op_r_tready = !fifo_empty && |(rsp_ready & head_oh);
  assign err         = 1'b0;
`endif

  assign pop = op_r_tvalid & op_r_tready & ~fifo_empty;

  assign op_a_tvalid = a_pend;
  assign op_b_tvalid = b_pend;
  assign op_a_tdata  = a_q;
  assign op_b_tdata  = b_q;
  assign busy        = a_pend | b_pend | (out_cnt != '0);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rr_ptr  <= '0;
      a_pend  <= 1'b0;
      b_pend  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      out_cnt <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else begin
      if (grant_any) begin
        a_q    <= req_a[grant_idx*DATA_SIZE +: DATA_SIZE];
        b_q    <= req_b[grant_idx*DATA_SIZE +: DATA_SIZE];
        a_pend <= 1'b1;
        b_pend <= 1'b1;
        wr_ptr <= wr_ptr + AW'(1);
        rr_ptr <= (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + PW'(1);
      end else begin
        if (a_hs) a_pend <= 1'b0;
        if (b_hs) b_pend <= 1'b0;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({grant_any, pop})
        2'b10:   out_cnt <= out_cnt + CW'(1);
        2'b01:   out_cnt <= out_cnt - CW'(1);
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (aresetn && grant_any) begin
      tag_mem[wr_ptr] <= grant_idx;
    end
  end

endmodule

// File: tb/tb_fop_arbiter.sv
// Directed self-checking bench for fop_arbiter; the bench plays the operator and requesters.
module tb_fop_arbiter;
  localparam int NREQ = 3;
  localparam int DS = 32;
  localparam int MAX_OUT = 8;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*DS-1:0] req_a, req_b;
  logic [NREQ-1:0] rsp_valid;
  logic [NREQ-1:0] rsp_ready = 3'b111;
  logic [DS-1:0] rsp_data;
  logic op_a_tvalid, op_b_tvalid;
  logic op_a_tready = 1'b1;
  logic op_b_tready = 1'b1;
  logic [DS-1:0] op_a_tdata, op_b_tdata;
  logic op_r_tvalid = 1'b0;
  logic op_r_tready;
  logic [DS-1:0] op_r_tdata = '0;
  logic busy, err;

  always #5 aclk = ~aclk;

  fop_arbiter #(.NREQ(NREQ), .DATA_SIZE(DS), .MAX_OUT(MAX_OUT)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .op_a_tvalid(op_a_tvalid), .op_a_tready(op_a_tready), .op_a_tdata(op_a_tdata),
    .op_b_tvalid(op_b_tvalid), .op_b_tready(op_b_tready), .op_b_tdata(op_b_tdata),
    .op_r_tvalid(op_r_tvalid), .op_r_tready(op_r_tready), .op_r_tdata(op_r_tdata),
    .busy(busy), .err(err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [2:0]  rv;
    logic        rtv;
    logic [2:0]  e_rdy;
    logic [2:0]  e_rsp;
    logic        e_rrdy;
    logic        e_busy;
    logic [31:0] e_a;
  } vec_t;

  vec_t tv[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    req_valid = '0;
    op_r_tvalid = 1'b0;
    step();
    step();
    aresetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int q[$];
    int grants;
    int pops;

    for (int i = 0; i < NREQ; i++) begin
      req_a[i*DS +: DS] = 32'hA000_0000 + i;
      req_b[i*DS +: DS] = 32'hB000_0000 + i;
    end

    // reset state
    step();
    step();
    settle();
    chk("rst_busy", busy, 0);
    chk("rst_a_tvalid", op_a_tvalid, 0);
    chk("rst_b_tvalid", op_b_tvalid, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_r_tready", op_r_tready, 0);
    chk("rst_err", err, 0);
    chk("rst_a_tdata", op_a_tdata, 0);
    aresetn = 1'b1;
    step();

    // single request, 1.0 + 2.0
    req_a[1*DS +: DS] = 32'h3F80_0000;
    req_b[1*DS +: DS] = 32'h4000_0000;
    req_valid = 3'b010;
    settle();
    chk("single_grant", req_ready, 3'b010);
    step();
    req_valid = '0;
    settle();
    chk("single_a_tvalid", op_a_tvalid, 1);
    chk("single_b_tvalid", op_b_tvalid, 1);
    chk("single_a_tdata", op_a_tdata, 32'h3F80_0000);
    chk("single_b_tdata", op_b_tdata, 32'h4000_0000);
    chk("single_busy", busy, 1);
    step();
    op_r_tvalid = 1'b1;
    op_r_tdata = 32'h4040_0000;
    settle();
    chk("single_a_done", op_a_tvalid, 0);
    chk("single_rsp_valid", rsp_valid, 3'b010);
    chk("single_rsp_data", rsp_data, 32'h4040_0000);
    chk("single_r_tready", op_r_tready, 1);
    step();
    op_r_tvalid = 1'b0;
    settle();
    chk("single_idle", busy, 0);
    chk("single_rsp_clear", rsp_valid, 0);
    req_a[1*DS +: DS] = 32'hA000_0001;
    req_b[1*DS +: DS] = 32'hB000_0001;

    // contention table
    do_reset();
    tv[0] = '{3'b111, 1'b0, 3'b001, 3'b000, 1'b0, 1'b0, 32'h0};
    tv[1] = '{3'b111, 1'b0, 3'b010, 3'b000, 1'b1, 1'b1, 32'hA000_0000};
    tv[2] = '{3'b111, 1'b0, 3'b100, 3'b000, 1'b1, 1'b1, 32'hA000_0001};
    tv[3] = '{3'b111, 1'b1, 3'b001, 3'b001, 1'b1, 1'b1, 32'hA000_0002};
    tv[4] = '{3'b111, 1'b1, 3'b010, 3'b010, 1'b1, 1'b1, 32'hA000_0000};
    tv[5] = '{3'b111, 1'b1, 3'b100, 3'b100, 1'b1, 1'b1, 32'hA000_0001};
    tv[6] = '{3'b000, 1'b1, 3'b000, 3'b001, 1'b1, 1'b1, 32'hA000_0002};
    tv[7] = '{3'b000, 1'b1, 3'b000, 3'b010, 1'b1, 1'b1, 32'hA000_0002};
    tv[8] = '{3'b000, 1'b1, 3'b000, 3'b100, 1'b1, 1'b1, 32'hA000_0002};
    tv[9] = '{3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 32'hA000_0002};
    for (int i = 0; i < 10; i++) begin
      req_valid = tv[i].rv;
      op_r_tvalid = tv[i].rtv;
      op_r_tdata = 32'hC0DE_0000 + i;
      settle();
      chk($sformatf("cont%0d_req_ready", i), req_ready, tv[i].e_rdy);
      chk($sformatf("cont%0d_rsp_valid", i), rsp_valid, tv[i].e_rsp);
      chk($sformatf("cont%0d_r_tready", i), op_r_tready, tv[i].e_rrdy);
      chk($sformatf("cont%0d_busy", i), busy, tv[i].e_busy);
      chk($sformatf("cont%0d_a_tdata", i), op_a_tdata, tv[i].e_a);
      if (tv[i].rtv) chk($sformatf("cont%0d_rsp_data", i), rsp_data, 32'hC0DE_0000 + i);
      step();
    end

    // split acceptance: A accepted at T+1, B held off until T+4
    req_valid = 3'b001;
    op_b_tready = 1'b0;
    settle();
    chk("split_T_grant", req_ready, 3'b001);
    step();
    req_valid = 3'b010;
    settle();
    chk("split_T1_ready", req_ready, 0);
    chk("split_T1_a", op_a_tvalid, 1);
    chk("split_T1_b", op_b_tvalid, 1);
    step();
    settle();
    chk("split_T2_a", op_a_tvalid, 0);
    chk("split_T2_b", op_b_tvalid, 1);
    chk("split_T2_ready", req_ready, 0);
    step();
    settle();
    chk("split_T3_ready", req_ready, 0);
    chk("split_T3_b", op_b_tvalid, 1);
    step();
    op_b_tready = 1'b1;
    settle();
    chk("split_T4_grant", req_ready, 3'b010);
    step();
    req_valid = '0;
    settle();
    chk("split_T5_b_new", op_b_tvalid, 1);
    chk("split_T5_b_data", op_b_tdata, 32'hB000_0001);
    chk("split_T5_a_data", op_a_tdata, 32'hA000_0001);
    step();
    settle();
    chk("split_T6_a", op_a_tvalid, 0);
    chk("split_T6_b", op_b_tvalid, 0);
    op_r_tvalid = 1'b1;
    settle();
    chk("split_rsp0", rsp_valid, 3'b001);
    step();
    settle();
    chk("split_rsp1", rsp_valid, 3'b010);
    step();
    op_r_tvalid = 1'b0;
    settle();
    chk("split_idle", busy, 0);

    // backpressure: latency 20, requester 0 streams
    do_reset();
    req_valid = 3'b001;
    grants = 0;
    pops = 0;
    for (int c = 0; c < 24; c++) begin
      op_r_tvalid = 1'b0;
      if (q.size() > 0) op_r_tvalid = (c >= q[0]);
      op_r_tdata = c;
      settle();
      chk($sformatf("bp_c%0d_ready", c), req_ready[0], (c < 8) || (c >= 22));
      if (req_ready[0]) begin
        grants++;
        q.push_back(c + 21);
      end
      if (op_r_tvalid && op_r_tready) begin
        void'(q.pop_front());
        pops++;
      end
      if (c == 21) chk("bp_grants_before_pop", grants, 8);
      step();
    end
    req_valid = '0;
    for (int c = 24; c < 100 && q.size() > 0; c++) begin
      op_r_tvalid = (c >= q[0]);
      op_r_tdata = c;
      settle();
      if (op_r_tvalid && op_r_tready) begin
        void'(q.pop_front());
        pops++;
      end
      step();
    end
    op_r_tvalid = 1'b0;
    settle();
    chk("bp_drained", q.size(), 0);
    chk("bp_grants", grants, 10);
    chk("bp_pops", pops, 10);
    chk("bp_idle", busy, 0);

    // head-of-line blocking
    do_reset();
    req_valid = 3'b011;
    settle();
    chk("hol_grant0", req_ready, 3'b001);
    step();
    settle();
    chk("hol_grant1", req_ready, 3'b010);
    step();
    req_valid = '0;
    rsp_ready = 3'b110;
    op_r_tvalid = 1'b1;
    op_r_tdata = 32'h1111_0000;
    for (int c = 0; c < 10; c++) begin
      settle();
      chk($sformatf("hol_c%0d_r_tready", c), op_r_tready, 0);
      chk($sformatf("hol_c%0d_rsp_valid", c), rsp_valid, 3'b001);
      step();
    end
    rsp_ready = 3'b111;
    settle();
    chk("hol_rel_rsp0", rsp_valid, 3'b001);
    chk("hol_rel_data0", rsp_data, 32'h1111_0000);
    chk("hol_rel_r_tready", op_r_tready, 1);
    step();
    op_r_tdata = 32'h2222_0000;
    settle();
    chk("hol_rel_rsp1", rsp_valid, 3'b010);
    chk("hol_rel_data1", rsp_data, 32'h2222_0000);
    step();
    op_r_tvalid = 1'b0;
    settle();
    chk("hol_idle", busy, 0);

    // orphan result with empty FIFO
    op_r_tvalid = 1'b1;
    op_r_tdata = 32'hDEAD_BEEF;
    settle();
`ifdef FOP_ARB_ERRCHK_EN
    chk("orphan_r_tready", op_r_tready, 1);
    chk("orphan_rsp_valid", rsp_valid, 0);
    step();
    op_r_tvalid = 1'b0;
    settle();
    chk("orphan_err", err, 1);
    step();
    step();
    settle();
    chk("orphan_err_sticky", err, 1);
`else
    chk("orphan_r_tready", op_r_tready, 0);
    chk("orphan_rsp_valid", rsp_valid, 0);
    step();
    op_r_tvalid = 1'b0;
    settle();
    chk("orphan_err", err, 0);
`endif

    // reset mid-stream
    req_valid = 3'b010;
    settle();
    chk("mid_grant", req_ready, 3'b010);
    step();
    req_valid = '0;
    settle();
    chk("mid_busy", busy, 1);
    aresetn = 1'b0;
    step();
    aresetn = 1'b1;
    settle();
    chk("mid_a_tvalid", op_a_tvalid, 0);
    chk("mid_b_tvalid", op_b_tvalid, 0);
    chk("mid_busy_clr", busy, 0);
    chk("mid_a_tdata", op_a_tdata, 0);
    chk("mid_err", err, 0);
    chk("mid_rsp_valid", rsp_valid, 0);
    req_valid = 3'b111;
    settle();
    chk("mid_rr_ptr0", req_ready, 3'b001);
    step();
    req_valid = '0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
